mix_columns_pipe: RTL and testbench

//  Parametrised, pipelined AES MixColumns/InvMixColumns engine. It processes NUM_COLS 32-bit columns per beat.
//  It has a valid/ready handshake on both sides and a tag that passes through with the data.
//  It sits between ShiftRows and AddRoundKey in the round datapath and replaces the per-byte combinational column mixers.

---
 rtl/mix_columns_pipe.sv | 174 +++++++++++++++++
 tb/tb_mix_columns_pipe.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_columns_pipe.sv
// Pipelined AES MixColumns / InvMixColumns engine with valid/ready and tag.
// Define INV_MIX_EN to build the inverse datapath selected by in_inv.
module mix_columns_pipe #(
  parameter int NUM_COLS = 4,
  parameter int PIPE     = 2,
  parameter int TAG_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_inv,
  input  logic [32*NUM_COLS-1:0] in_data,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*NUM_COLS-1:0] out_data,
  output logic [TAG_W-1:0]      out_tag
);

  localparam int W = 32 * NUM_COLS;

  function automatic logic [7:0] xt(
    input logic [7:0] x
  );
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] fwd_col(
    input logic [31:0] c
  );
    logic [7:0] a [4];
    logic [7:0] t [4];
    for (int i = 0; i < 4; i++) begin
      a[i] = c[31-8*i -: 8];
      t[i] = xt(a[i]);
    end
    return {
      t[0] ^ t[1] ^ a[1] ^ a[2] ^ a[3],
      a[0] ^ t[1] ^ t[2] ^ a[2] ^ a[3],
      a[0] ^ a[1] ^ t[2] ^ t[3] ^ a[3],
      t[0] ^ a[0] ^ a[1] ^ a[2] ^ t[3]
    };
  endfunction

`ifdef INV_MIX_EN
  function automatic logic [31:0] inv_col(
    input logic [31:0] c
  );
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2    = xt(a[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {
      me[0] ^ mb[1] ^ md[2] ^ m9[3],
      m9[0] ^ me[1] ^ mb[2] ^ md[3],
      md[0] ^ m9[1] ^ me[2] ^ mb[3],
      mb[0] ^ md[1] ^ m9[2] ^ me[3]
    };
  endfunction

  function automatic logic [W-1:0] mix(
    input logic [W-1:0] d,
    input logic         inv
  );
    logic [W-1:0] r;
    logic [31:0]  c;
    r = '0;
    for (int k = 0; k < NUM_COLS; k++) begin
      c = d[W-1-32*k -: 32];
      r[W-1-32*k -: 32] = inv ? inv_col(c)
                              : fwd_col(c);
    end
    return r;
  endfunction
`else
  function automatic logic [W-1:0] mix(
    input logic [W-1:0] d
  );
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_COLS; k++)
      r[W-1-32*k -: 32] = fwd_col(d[W-1-32*k -: 32]);
    return r;
  endfunction

  logic unused_inv;
  assign unused_inv = in_inv;
`endif

  logic             f_valid;
  logic [W-1:0]     f_data;
  logic [TAG_W-1:0] f_tag;
  logic             f_inv;
  logic             s1_ready;

  assign s1_ready = !out_valid || out_ready;

  if (PIPE == 2) begin : g_in
    logic             s0_valid;
    logic             s0_advance;
    logic [W-1:0]     s0_data;
    logic [TAG_W-1:0] s0_tag;
    logic             s0_inv;

    assign s0_advance = s0_valid && s1_ready;
    assign in_ready   = !s0_valid || s0_advance;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s0_valid <= 1'b0;
        s0_data  <= '0;
        s0_tag   <= '0;
        s0_inv   <= 1'b0;
      end else begin
        if (in_ready)
          s0_valid <= in_valid;
        if (in_valid && in_ready) begin
          s0_data <= in_data;
          s0_tag  <= in_tag;
          s0_inv  <= in_inv;
        end
      end
    end

    assign f_valid = s0_valid;
    assign f_data  = s0_data;
    assign f_tag   = s0_tag;
    assign f_inv   = s0_inv;
  end else begin : g_bypass
    assign in_ready = s1_ready;
    assign f_valid  = in_valid;
    assign f_data   = in_data;
    assign f_tag    = in_tag;
    assign f_inv    = in_inv;
  end

  logic [W-1:0] f_mixed;
`ifdef INV_MIX_EN
  assign f_mixed = mix(f_data, f_inv);
`else
  assign f_mixed = mix(f_data);
  logic unused_f_inv;
  assign unused_f_inv = f_inv;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
    end else begin
      if (s1_ready)
        out_valid <= f_valid;
      if (f_valid && s1_ready) begin
        out_data <= f_mixed;
        out_tag  <= f_tag;
      end
    end
  end

endmodule

// File: tb/tb_mix_columns_pipe.sv
// Bench for mix_columns_pipe: directed vectors, ordering, stall, reset,
// and random traffic against a GF(2^8) matrix reference model.
module tb_mix_columns_pipe;

  localparam int NC   = 4;
  localparam int PIPE = 2;
  localparam int TW   = 4;
  localparam int W    = 32 * NC;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_inv = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [TW-1:0] out_tag;

  int total = 0;
  int bad   = 0;

  logic [W+TW-1:0] exp_q [$];

  mix_columns_pipe #(
    .NUM_COLS(NC), .PIPE(PIPE), .TAG_W(TW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inv(in_inv), .in_data(in_data),
    .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(
    input logic [7:0] a, input logic [7:0] b
  );
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--)
      if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [W-1:0] ref_mix(
    input logic [W-1:0] d, input logic inv
  );
    logic [7:0] row [4];
    logic [7:0] a [4];
    logic [7:0] b;
    logic [W-1:0] r;
    logic eff;
`ifdef INV_MIX_EN
    eff = inv;
`else
    eff = 1'b0 & inv;
`endif
    if (eff) row = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     row = '{8'h02, 8'h03, 8'h01, 8'h01};
    r = '0;
    for (int c = 0; c < NC; c++) begin
      for (int k = 0; k < 4; k++)
        a[k] = d[W-1-32*c-8*k -: 8];
      for (int rr = 0; rr < 4; rr++) begin
        b = '0;
        for (int k = 0; k < 4; k++)
          b ^= gmul(row[(k - rr + 4) % 4], a[k]);
        r[W-1-32*c-8*rr -: 8] = b;
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_data();
    logic [W-1:0] d;
    for (int i = 0; i < NC; i++)
      d[32*i +: 32] = $urandom;
    return d;
  endfunction

  task automatic drive(
    input logic v, input logic inv,
    input logic [W-1:0] d, input logic [TW-1:0] t,
    input logic ordy
  );
    @(negedge clk);
    in_valid  = v;
    in_inv    = inv;
    in_data   = d;
    in_tag    = t;
    out_ready = ordy;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_tag !== '0) begin
      bad++;
      $display("FAIL reset_state v=%b d=%h t=%h want 0/0/0",
               out_valid, out_data, out_tag);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release in_ready=%b out_valid=%b want 1/0",
               in_ready, out_valid);
    end
  endtask

  task automatic directed(
    input string nm, input logic inv,
    input logic [W-1:0] din, input logic [W-1:0] want
  );
    int n;
    drive(1'b1, inv, din, 4'h5, 1'b1);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_accept in_ready=%b want 1", nm, in_ready);
    end
    n = 0;
    do begin
      drive(1'b0, 1'b0, '0, '0, 1'b1);
      n++;
    end while (!out_valid && n < 20);
    total++;
    if (n != PIPE) begin
      bad++;
      $display("FAIL %s_latency got %0d want %0d", nm, n, PIPE);
    end
    total++;
    if (out_data !== want || out_tag !== 4'h5) begin
      bad++;
      $display("FAIL %s_data got %h/%h want %h/5",
               nm, out_data, out_tag, want);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] d;
    logic [W+TW-1:0] e;
    int cyc, outs;
    cyc = 0;
    outs = 0;
    for (int i = 0; i < 8 + PIPE + 2; i++) begin
      if (i < 8) begin
        d = rnd_data();
        drive(1'b1, i[0], d, i[TW-1:0], 1'b1);
        total++;
        if (in_ready !== 1'b1) begin
          bad++;
          $display("FAIL b2b_ready cyc=%0d in_ready=%b want 1", i, in_ready);
        end
        exp_q.push_back({ref_mix(d, i[0]), i[TW-1:0]});
      end else begin
        drive(1'b0, 1'b0, '0, '0, 1'b1);
      end
      if (out_valid) begin
        total++;
        e = exp_q.pop_front();
        if (out_tag !== TW'(outs) || cyc != outs + PIPE ||
            {out_data, out_tag} !== e) begin
          bad++;
          $display("FAIL b2b_out cyc=%0d tag=%h d=%h want cyc=%0d %h",
                   cyc, out_tag, out_data, outs + PIPE, e);
        end
        outs++;
      end
      cyc++;
    end
    total++;
    if (outs != 8) begin
      bad++;
      $display("FAIL b2b_count got %0d want 8", outs);
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] d, held;
    logic [W+TW-1:0] e;
    int acc, n;
    acc = 0;
    n = 0;
    do begin
      d = rnd_data();
      drive(1'b1, d[0], d, TW'(acc), 1'b0);
      if (in_ready) begin
        exp_q.push_back({ref_mix(d, d[0]), TW'(acc)});
        acc++;
      end
      n++;
    end while (in_ready && n < 10);
    total++;
    if (acc != PIPE) begin
      bad++;
      $display("FAIL stall_fill got %0d want %0d", acc, PIPE);
    end
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, rnd_data(), 4'hf, 1'b0);
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
          out_data !== held) begin
        bad++;
        $display("FAIL stall_hold rdy=%b v=%b d=%h want 0/1/%h",
                 in_ready, out_valid, out_data, held);
      end
    end
    n = 0;
    while ((exp_q.size() > 0 || acc < PIPE + 3) && n < 30) begin
      d = rnd_data();
      if (acc < PIPE + 3) drive(1'b1, d[1], d, TW'(acc), 1'b1);
      else                drive(1'b0, 1'b0, '0, '0, 1'b1);
      if (n == 0) begin
        total++;
        if (in_ready !== 1'b1) begin
          bad++;
          $display("FAIL stall_release in_ready=%b want 1", in_ready);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({ref_mix(d, d[1]), TW'(acc)});
        acc++;
      end
      if (out_valid && out_ready) begin
        total++;
        e = exp_q.pop_front();
        if ({out_data, out_tag} !== e) begin
          bad++;
          $display("FAIL stall_drain got %h/%h want %h",
                   out_data, out_tag, e);
        end
      end
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL stall_timeout left=%0d want 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_stall();
    logic [W-1:0] d;
    drive(1'b1, 1'b0, rnd_data(), 4'h1, 1'b0);
    drive(1'b1, 1'b1, rnd_data(), 4'h2, 1'b0);
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL midrst_pre out_valid=%b want 1", out_valid);
    end
    rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_tag !== '0) begin
      bad++;
      $display("FAIL midrst_now v=%b d=%h t=%h want 0/0/0",
               out_valid, out_data, out_tag);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    d = rnd_data();
    directed("midrst_next", 1'b0, d, ref_mix(d, 1'b0));
  endtask

  task automatic test_random();
    logic [W-1:0] d;
    logic [W+TW-1:0] e;
    logic inv;
    int n;
    for (int i = 0; i < 300; i++) begin
      d = rnd_data();
      inv = $urandom_range(0, 1);
      drive($urandom_range(0, 3) != 0, inv, d, TW'(i),
            $urandom_range(0, 2) != 0);
      if (in_valid && in_ready)
        exp_q.push_back({ref_mix(d, inv), TW'(i)});
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rnd_extra got %h/%h", out_data, out_tag);
        end else begin
          e = exp_q.pop_front();
          if ({out_data, out_tag} !== e) begin
            bad++;
            $display("FAIL rnd_data got %h/%h want %h",
                     out_data, out_tag, e);
          end
        end
      end
    end
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      drive(1'b0, 1'b0, '0, '0, 1'b1);
      if (out_valid) begin
        total++;
        e = exp_q.pop_front();
        if ({out_data, out_tag} !== e) begin
          bad++;
          $display("FAIL rnd_drain got %h/%h want %h",
                   out_data, out_tag, e);
        end
      end
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL rnd_timeout left=%0d want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    directed("fwd_vec", 1'b0,
             128'hdb135345_f20a225c_01010101_c6c6c6c6,
             128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
`ifdef INV_MIX_EN
    directed("inv_vec", 1'b1,
             128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6,
             128'hdb135345_f20a225c_01010101_c6c6c6c6);
`else
    directed("inv_ignored", 1'b1,
             {4{32'hd4bf5d30}}, {4{32'h046681e5}});
`endif
    do_reset();
    test_back_to_back();
    do_reset();
    test_stall();
    do_reset();
    test_reset_mid_stall();
    do_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
